// File: rtl/hint_pkg.sv
// Shared types and constants for the hint reveal sequencer.
package hint_pkg;

  localparam int HINT_MAX_LEVEL = 3;
  localparam int MAX_WORD_LEN   = 8;
  localparam int IDX_W          = 3;
  localparam int LEN_W          = 4;
  localparam int CNT_W          = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } hint_state_e;

  // (base + inc) mod len for base < len <= 8 and inc <= 3; two folds cover len = 2
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [1:0]       inc,
                                                input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] sum;
    sum = {1'b0, base} + {2'b00, inc};
    if (sum >= len) begin
      sum = sum - len;
    end else begin
      sum = sum;
    end
    if (sum >= len) begin
      sum = sum - len;
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/reveal_interval_timer.sv
// Counts seconds ticks and flags the tick that completes one reveal interval.
module reveal_interval_timer
  import hint_pkg::*;
#(
  parameter int REVEAL_INTERVAL = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REVEAL_INTERVAL - 1);

  logic [CNT_W-1:0] count_r;

  assign expire = tick && !clear && (count_r == LAST_COUNT);

  // Tick counter; wraps to zero on the expiring tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      count_r <= expire ? {CNT_W{1'b0}} : count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/hint_reveal_sequencer.sv
// Reveals letters of the secret word at a fixed tick interval, never the whole word.
module hint_reveal_sequencer
  import hint_pkg::*;
#(
  parameter int REVEAL_INTERVAL = 10,
  parameter int MAX_WORD_LEN    = hint_pkg::MAX_WORD_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    round_start,
  input  logic                    round_end,
  input  logic [2:0]              hint_level,
  input  logic [3:0]              word_len,
  input  logic                    tick_1hz,
  output logic [MAX_WORD_LEN-1:0] reveal_mask,
  output logic                    reveal_pulse,
  output logic [IDX_W-1:0]        reveal_idx,
  output logic                    done
);

  hint_state_e             state_r, state_s;
  logic [MAX_WORD_LEN-1:0] mask_r, mask_s;
  logic [IDX_W-1:0]        ptr_r, ptr_s;
  logic [IDX_W-1:0]        count_r, count_s;
  logic [IDX_W-1:0]        target_r, target_s;
  logic [LEN_W-1:0]        len_r, len_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic                    pulse_r, pulse_s;
  logic                    done_r, done_s;
  logic [1:0]              lvl_s;
  logic                    expire_s;

  reveal_interval_timer #(
    .REVEAL_INTERVAL(REVEAL_INTERVAL)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (round_start || round_end),
    .tick  (tick_1hz && (state_r == ST_WAIT)),
    .expire(expire_s)
  );

  // Next-state, mask and counter logic
  always_comb begin
    state_s  = state_r;
    mask_s   = mask_r;
    ptr_s    = ptr_r;
    count_s  = count_r;
    target_s = target_r;
    len_s    = len_r;
    idx_s    = idx_r;
    pulse_s  = 1'b0;
    done_s   = done_r;
    lvl_s    = (hint_level > 3'(HINT_MAX_LEVEL)) ? 2'(HINT_MAX_LEVEL) : hint_level[1:0];
    if (round_start) begin
      if (word_len == 4'd0) begin
        len_s = 4'd1;
      end else if (word_len > LEN_W'(MAX_WORD_LEN)) begin
        len_s = LEN_W'(MAX_WORD_LEN);
      end else begin
        len_s = word_len;
      end
      target_s = ({2'b00, lvl_s} < (len_s - 4'd1)) ? {1'b0, lvl_s} : IDX_W'(len_s - 4'd1);
      mask_s   = {MAX_WORD_LEN{1'b0}};
      count_s  = {IDX_W{1'b0}};
      ptr_s    = {IDX_W{1'b0}};
      done_s   = (target_s == {IDX_W{1'b0}});
      state_s  = done_s ? ST_DONE : ST_WAIT;
    end else if (round_end) begin
      state_s = ST_IDLE;
      mask_s  = {MAX_WORD_LEN{1'b0}};
      count_s = {IDX_W{1'b0}};
      ptr_s   = {IDX_W{1'b0}};
      done_s  = 1'b0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (expire_s) begin
            state_s = ST_SEARCH;
            ptr_s   = (count_r == {IDX_W{1'b0}}) ? IDX_W'(1) : wrap_add(idx_r, 2'd3, len_r);
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_SEARCH: begin
          if (mask_r[ptr_r]) begin
            ptr_s = wrap_add(ptr_r, 2'd1, len_r);
          end else begin
            mask_s[ptr_r] = 1'b1;
            pulse_s       = 1'b1;
            idx_s         = ptr_r;
            count_s       = count_r + IDX_W'(1);
            done_s        = (count_s == target_r);
            state_s       = done_s ? ST_DONE : ST_WAIT;
          end
        end
        ST_IDLE: state_s = ST_IDLE;
        ST_DONE: state_s = ST_DONE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      mask_r   <= {MAX_WORD_LEN{1'b0}};
      ptr_r    <= {IDX_W{1'b0}};
      count_r  <= {IDX_W{1'b0}};
      target_r <= {IDX_W{1'b0}};
      len_r    <= LEN_W'(1);
      idx_r    <= {IDX_W{1'b0}};
      pulse_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      mask_r   <= mask_s;
      ptr_r    <= ptr_s;
      count_r  <= count_s;
      target_r <= target_s;
      len_r    <= len_s;
      idx_r    <= idx_s;
      pulse_r  <= pulse_s;
      done_r   <= done_s;
    end
  end

  assign reveal_mask  = mask_r;
  assign reveal_pulse = pulse_r;
  assign reveal_idx   = idx_r;
  assign done         = done_r;

endmodule

// File: tb/tb_hint_reveal_sequencer.sv
// Scoreboard bench for hint_reveal_sequencer with REVEAL_INTERVAL=2.
module tb_hint_reveal_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       round_start = 1'b0;
  logic       round_end = 1'b0;
  logic [2:0] hint_level = 3'd0;
  logic [3:0] word_len = 4'd0;
  logic       tick_1hz = 1'b0;
  logic [7:0] reveal_mask;
  logic       reveal_pulse;
  logic [2:0] reveal_idx;
  logic       done;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hint_reveal_sequencer #(
    .REVEAL_INTERVAL(2),
    .MAX_WORD_LEN   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .round_start (round_start),
    .round_end   (round_end),
    .hint_level  (hint_level),
    .word_len    (word_len),
    .tick_1hz    (tick_1hz),
    .reveal_mask (reveal_mask),
    .reveal_pulse(reveal_pulse),
    .reveal_idx  (reveal_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] idx, input logic [7:0] mask);
    exp_t e;
    e.idx  = idx;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] lvl, input logic [3:0] len, input logic with_end);
    @(posedge clk);
    #1;
    round_start = 1'b1;
    round_end   = with_end;
    hint_level  = lvl;
    word_len    = len;
    @(posedge clk);
    #1;
    round_start = 1'b0;
    round_end   = 1'b0;
    hint_level  = 3'd0;
    word_len    = 4'd0;
  endtask

  task automatic end_round();
    @(posedge clk);
    #1;
    round_end = 1'b1;
    @(posedge clk);
    #1;
    round_end = 1'b0;
  endtask

  // One tick pulse followed by enough idle cycles for any search to finish
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tick_1hz = 1'b1;
      @(posedge clk);
      #1;
      tick_1hz = 1'b0;
      idle(12);
    end
  endtask

  // Monitor: every reveal pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst && reveal_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_reveal: got idx %0d mask 0x%0h expected none", reveal_idx, reveal_mask);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("reveal_idx", 32'(reveal_idx), 32'(e.idx));
        chk("reveal_mask_at_pulse", 32'(reveal_mask), 32'(e.mask));
      end
    end
  end

  initial begin
    logic [7:0] mask_seq [6];
    mask_seq[0] = 8'h00; mask_seq[1] = 8'h02; mask_seq[2] = 8'h02;
    mask_seq[3] = 8'h12; mask_seq[4] = 8'h12; mask_seq[5] = 8'h16;

    idle(3);
    chk("reset_mask", 32'(reveal_mask), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_pulse", 32'(reveal_pulse), 32'h0);
    chk("reset_idx", 32'(reveal_idx), 32'h0);
    rst = 1'b1;
    idle(2);

    // Full length-5 round: idx 1, 4, 2
    push(3'd1, 8'h02); push(3'd4, 8'h12); push(3'd2, 8'h16);
    start(3'd3, 4'd5, 1'b0);
    chk("r5_start_mask", 32'(reveal_mask), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk($sformatf("r5_mask_tick%0d", i + 1), 32'(reveal_mask), 32'(mask_seq[i]));
    end
    chk("r5_done", 32'(done), 32'h1);
    tick(4);
    chk("r5_hold_mask", 32'(reveal_mask), 32'h16);

    // Length 3: second search skips idx 1
    push(3'd1, 8'h02); push(3'd2, 8'h06);
    start(3'd3, 4'd3, 1'b0);
    tick(2);
    chk("r3_done_mid", 32'(done), 32'h0);
    tick(2);
    chk("r3_mask", 32'(reveal_mask), 32'h06);
    chk("r3_done", 32'(done), 32'h1);

    // Zero-target rounds
    start(3'd0, 4'd5, 1'b0);
    chk("lvl0_done", 32'(done), 32'h1);
    tick(10);
    chk("lvl0_mask", 32'(reveal_mask), 32'h0);
    start(3'd3, 4'd1, 1'b0);
    chk("len1_done", 32'(done), 32'h1);
    tick(10);
    chk("len1_mask", 32'(reveal_mask), 32'h0);
    start(3'd3, 4'd0, 1'b0);
    chk("len0_done", 32'(done), 32'h1);

    // Clamping: level 7 -> 3, length 15 -> 8
    push(3'd1, 8'h02); push(3'd4, 8'h12); push(3'd7, 8'h92);
    start(3'd7, 4'd15, 1'b0);
    tick(6);
    chk("clamp_mask", 32'(reveal_mask), 32'h92);
    chk("clamp_done", 32'(done), 32'h1);

    // Abort after first reveal
    push(3'd1, 8'h02);
    start(3'd3, 4'd5, 1'b0);
    tick(2);
    chk("abort_pre_mask", 32'(reveal_mask), 32'h02);
    end_round();
    chk("abort_mask", 32'(reveal_mask), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    tick(6);
    chk("abort_idle_mask", 32'(reveal_mask), 32'h0);

    // Simultaneous start and end mid-round, tick counter must restart
    push(3'd1, 8'h02);
    start(3'd3, 4'd5, 1'b0);
    tick(3);
    start(3'd2, 4'd8, 1'b1);
    chk("restart_mask", 32'(reveal_mask), 32'h0);
    chk("restart_done", 32'(done), 32'h0);
    push(3'd1, 8'h02);
    tick(1);
    chk("restart_tick1_mask", 32'(reveal_mask), 32'h0);
    tick(1);
    chk("restart_tick2_mask", 32'(reveal_mask), 32'h02);
    push(3'd4, 8'h12);
    tick(2);
    chk("restart_final_mask", 32'(reveal_mask), 32'h12);
    chk("restart_done_final", 32'(done), 32'h1);

    // Asynchronous reset between edges mid-WAIT
    push(3'd1, 8'h02);
    start(3'd3, 4'd5, 1'b0);
    tick(3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_mask", 32'(reveal_mask), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_idx", 32'(reveal_idx), 32'h0);
    idle(2);
    rst = 1'b1;
    tick(6);
    chk("arst_idle_mask", 32'(reveal_mask), 32'h0);
    chk("arst_idle_done", 32'(done), 32'h0);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hint_reveal_sequencer.md
HINT_REVEAL_SEQUENCER -- requirements
Module: hint_reveal_sequencer

Interface
REQ-001 The block SHALL have parameter REVEAL_INTERVAL, default 10: number of tick_1hz pulses between successive letter reveals (legal 1..63).
REQ-002 The block SHALL have parameter MAX_WORD_LEN, default 8: number of letter positions, one mask bit each.
REQ-003 The block SHALL have one clock, port clk, rising edge.
REQ-004 The block SHALL have reset port rst, input, 1 bit, asynchronous, active-low.
REQ-005 The block SHALL have round_start, input, 1: one-cycle pulse that starts a round.
REQ-006 The block SHALL have round_end, input, 1: one-cycle pulse that aborts or ends a round.
REQ-007 The block SHALL have hint_level, input, 3: upstream randomizer output, read only when round_start=1.
REQ-008 The block SHALL have word_len, input, 4: secret-word length, read only when round_start=1.
REQ-009 The block SHALL have tick_1hz, input, 1: one-cycle seconds strobe.
REQ-010 The block SHALL have reveal_mask, output, 8: bit i=1 means letter i is shown.
REQ-011 The block SHALL have reveal_pulse, output, 1: one-cycle strobe for a new reveal.
REQ-012 The block SHALL have reveal_idx, output, 3: index revealed, valid while reveal_pulse=1.
REQ-013 The block SHALL have done, output, 1: all hints for the round are issued.

Function
REQ-014 When round_start=1, the block SHALL latch lvl=min(hint_level,3) and len=word_len clamped to 1..8 (0->1, >8->8).
REQ-015 When round_start=1, the block SHALL set target=min(lvl,len-1), so the whole word is never revealed.
REQ-016 When round_start=1, the block SHALL clear reveal_mask, the reveal count and the tick counter.
REQ-017 The block SHALL implement states IDLE, WAIT, SEARCH and DONE.
REQ-018 On round_start, the next state SHALL be DONE if target=0, otherwise WAIT.
REQ-019 In WAIT, each tick_1hz SHALL increment the tick counter; on the tick that makes it REVEAL_INTERVAL, the block SHALL clear the counter and go to SEARCH.
REQ-020 On entry to SEARCH, ptr SHALL be 1 for the first reveal, otherwise (last reveal_idx+3) mod len.
REQ-021 In SEARCH, if reveal_mask[ptr]=1 then ptr SHALL become (ptr+1) mod len, evaluated one position per cycle.
REQ-022 In SEARCH, if reveal_mask[ptr]=0 then on that same edge the block SHALL set mask bit ptr, assert reveal_pulse for one cycle with reveal_idx=ptr, and increment the count.
REQ-023 After a reveal, the next state SHALL be DONE if count=target, otherwise WAIT.
REQ-024 SEARCH SHALL terminate within len cycles; this is guaranteed because target<len.
REQ-025 In DONE, done SHALL be 1 and reveal_mask SHALL hold until round_start, round_end or reset.
REQ-026 round_end SHALL return the block to IDLE and clear reveal_mask, done and the counters.
REQ-027 If round_start and round_end are asserted in the same cycle, round_start SHALL take priority.
REQ-028 round_start in any state, including mid-SEARCH, SHALL restart the round per REQ-014..REQ-016.
REQ-029 tick_1hz SHALL be ignored outside WAIT.
REQ-030 reveal_mask bits at positions >= len SHALL remain 0.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While rst=0, the block SHALL asynchronously force state=IDLE, reveal_mask=0, reveal_pulse=0, reveal_idx=0, done=0, counters=0 and ptr=0.
REQ-033 Reset deassertion SHALL be synchronized externally; the block SHALL resume in IDLE on the first clk edge after rst=1.

Structure
REQ-034 Shared package hint_pkg SHALL hold the state enum, HINT_MAX_LEVEL=3 and MAX_WORD_LEN=8.
REQ-035 The tick counter SHALL be the sub-module reveal_interval_timer, with ports clk, rst, clear, tick, expire.
REQ-036 The FSM and mask logic SHALL stay in the top module.

Verification (REVEAL_INTERVAL=2)
REQ-037 round_start with hint_level=3, word_len=5, then 6 ticks -> reveals at idx 1, 4, 2 after ticks 2, 4, 6; final mask=0x16; done=1.
REQ-038 round_start with hint_level=3, word_len=3 -> reveals idx 1 then idx 2 (idx 1 is skipped by one search cycle); mask=0x06; done after 2 reveals.
REQ-039 round_start with hint_level=0, or with word_len=1 -> done=1 one cycle later; mask=0; no reveal_pulse for 10 ticks.
REQ-040 round_end pulsed after the first reveal -> state IDLE, mask=0, done=0; subsequent ticks cause no reveals.
REQ-041 round_start and round_end in the same cycle mid-round, with hint_level=2, word_len=8 -> new round begins; mask=0; first reveal at idx 1 after 2 ticks.
REQ-042 rst=0 asserted mid-WAIT between edges -> outputs go to 0 immediately; after release, no activity until round_start.
